// File: rtl/pw_ub_pkg.sv
// Shared types and address helpers for the pointwise unified buffer.
package pw_ub_pkg;

  localparam int unsigned CTRL_W  = 16;
  localparam int unsigned BANKS_X = 2;
  localparam int unsigned BANKS_Y = 2;
  localparam int unsigned NBANKS  = BANKS_X * BANKS_Y;

  typedef logic [2:0][CTRL_W-1:0] ctrl_vec_t;

  // Bank index: cyclic in x, then y; bank counts are powers of two so masks suffice.
  function automatic int unsigned bank_of(input int unsigned x, input int unsigned y,
                                          input int unsigned lbx, input int unsigned lby);
    int unsigned mx;
    int unsigned my;
    mx = x & ((32'd1 << lbx) - 32'd1);
    my = y & ((32'd1 << lby) - 32'd1);
    return mx + (my << lbx);
  endfunction

  function automatic int unsigned bank_addr(input int unsigned x, input int unsigned y,
                                            input int unsigned lbx, input int unsigned lby,
                                            input int unsigned row_words);
    return (x >> lbx) + row_words * (y >> lby);
  endfunction

endpackage

// File: rtl/pw_ub_delay_line.sv
// Circular delay line: reader sees the word pushed SR_DEPTH pushes earlier.
// Optional PW_UB_RAW_BYPASS_EN forwards a simultaneous push when SR_DEPTH==1.
module pw_ub_delay_line #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SR_DEPTH = 4,
  parameter int unsigned FILL_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [FILL_W-1:0] o_fill
);

  localparam int unsigned PTR_W = (SR_DEPTH > 1) ? $clog2(SR_DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [SR_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [FILL_W-1:0] r_fill;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              w_full;
  logic [DATA_W-1:0] w_rd_word;

  assign w_full = (r_fill == FILL_W'(SR_DEPTH));

  // The slot at wptr is the oldest entry and is read before this cycle's push lands.
`ifdef PW_UB_RAW_BYPASS_EN
  if (SR_DEPTH == 1) begin : g_fwd
    assign w_rd_word = i_push ? i_data : r_mem[r_wptr];
  end else begin : g_nofwd
    assign w_rd_word = r_mem[r_wptr];
  end
`else
  assign w_rd_word = r_mem[r_wptr];
`endif

  always_ff @(posedge clk) begin
    if (i_push && !flush) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_fill  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_push) begin
        r_wptr <= (r_wptr == PTR_W'(SR_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
        if (!w_full) r_fill <= r_fill + FILL_W'(1);
      end
      r_valid <= i_pop && w_full;
      if (i_pop && w_full) r_data <= w_rd_word;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_fill  = r_fill;

endmodule

// File: rtl/pw_ub_banked_sr.sv
// Unified buffer: cyclic-banked 2-D storage (SR_DEPTH==0) or fixed delay line (SR_DEPTH>0).
// Optional PW_UB_RAW_BYPASS_EN forwards same-address write data to a same-cycle read.
module pw_ub_banked_sr
  import pw_ub_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned BANKS_X    = 2,
  parameter int unsigned BANKS_Y    = 2,
  parameter int unsigned EXTENT_X   = 64,
  parameter int unsigned BANK_DEPTH = 1024,
  parameter int unsigned SR_DEPTH   = 0,
  localparam int unsigned FILL_W    = (SR_DEPTH > 0) ? $clog2(SR_DEPTH + 1) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                wr_wen,
  input  logic [3*CTRL_W-1:0] wr_ctrl_vars,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_ren,
  input  logic [3*CTRL_W-1:0] rd_ctrl_vars,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                err_oob,
  output logic [FILL_W-1:0]   sr_fill
);

  if (SR_DEPTH == 0) begin : g_banked
    localparam int unsigned LBX       = $clog2(BANKS_X);
    localparam int unsigned LBY       = $clog2(BANKS_Y);
    localparam int unsigned NB        = BANKS_X * BANKS_Y;
    localparam int unsigned ROW_WORDS = EXTENT_X / BANKS_X;
    localparam int unsigned MEM_WORDS = NB * BANK_DEPTH;
    localparam int unsigned MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [DATA_W-1:0] r_mem [MEM_WORDS];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_err_oob;
    logic [CTRL_W-1:0] w_wr_x, w_wr_y, w_rd_x, w_rd_y;
    logic [31:0]       w_wr_bank, w_wr_addr, w_rd_bank, w_rd_addr;
    logic [MEM_AW-1:0] w_wr_idx, w_rd_idx;
    logic              w_wr_oob, w_rd_oob, w_wr_go, w_rd_go;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_unused_outer;

    assign w_wr_x = wr_ctrl_vars[2*CTRL_W-1:CTRL_W];
    assign w_wr_y = wr_ctrl_vars[3*CTRL_W-1:2*CTRL_W];
    assign w_rd_x = rd_ctrl_vars[2*CTRL_W-1:CTRL_W];
    assign w_rd_y = rd_ctrl_vars[3*CTRL_W-1:2*CTRL_W];
    assign w_unused_outer = ^{wr_ctrl_vars[CTRL_W-1:0], rd_ctrl_vars[CTRL_W-1:0]};

    assign w_wr_bank = bank_of(32'(w_wr_x), 32'(w_wr_y), LBX, LBY);
    assign w_wr_addr = bank_addr(32'(w_wr_x), 32'(w_wr_y), LBX, LBY, ROW_WORDS);
    assign w_rd_bank = bank_of(32'(w_rd_x), 32'(w_rd_y), LBX, LBY);
    assign w_rd_addr = bank_addr(32'(w_rd_x), 32'(w_rd_y), LBX, LBY, ROW_WORDS);

    assign w_wr_oob = (32'(w_wr_x) >= EXTENT_X) || (w_wr_addr >= BANK_DEPTH);
    assign w_rd_oob = (32'(w_rd_x) >= EXTENT_X) || (w_rd_addr >= BANK_DEPTH);
    assign w_wr_go  = wr_wen && !w_wr_oob && !flush;
    assign w_rd_go  = rd_ren && !w_rd_oob;

    // All banks share one flat array; bank index forms the upper address field.
    assign w_wr_idx = MEM_AW'(w_wr_bank * BANK_DEPTH + w_wr_addr);
    assign w_rd_idx = MEM_AW'(w_rd_bank * BANK_DEPTH + w_rd_addr);

`ifdef PW_UB_RAW_BYPASS_EN
    assign w_rd_word = (w_wr_go && (w_wr_idx == w_rd_idx)) ? wr_data : r_mem[w_rd_idx];
`else
    assign w_rd_word = r_mem[w_rd_idx];
`endif

    always_ff @(posedge clk) begin
      if (w_wr_go) r_mem[w_wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
        r_err_oob  <= 1'b0;
      end else if (flush) begin
        r_rd_valid <= 1'b0;
        r_err_oob  <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_go;
        r_err_oob  <= (wr_wen && w_wr_oob) || (rd_ren && w_rd_oob);
        if (w_rd_go) r_rd_data <= w_rd_word;
      end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign err_oob  = r_err_oob;
    assign sr_fill  = '0;
  end else begin : g_delay
    logic w_unused_ctrl;

    assign w_unused_ctrl = ^{wr_ctrl_vars, rd_ctrl_vars};

    pw_ub_delay_line #(
      .DATA_W  (DATA_W),
      .SR_DEPTH(SR_DEPTH),
      .FILL_W  (FILL_W)
    ) u_delay_line (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .i_push (wr_wen),
      .i_pop  (rd_ren),
      .i_data (wr_data),
      .o_data (rd_data),
      .o_valid(rd_valid),
      .o_fill (sr_fill)
    );

    assign err_oob = 1'b0;
  end

endmodule

// File: tb/tb_pw_ub_banked_sr.sv
// Directed bench: one banked instance (SR_DEPTH=0) and one delay-line instance (SR_DEPTH=4).
module tb_pw_ub_banked_sr;

  logic        clk;
  logic        rst_n;

  logic        b_flush, b_wen, b_ren;
  logic [47:0] b_wcv, b_rcv;
  logic [15:0] b_wdata, b_rdata;
  logic        b_rvalid, b_err;
  logic [0:0]  b_fill;

  logic        s_flush, s_wen, s_ren;
  logic [47:0] s_wcv, s_rcv;
  logic [15:0] s_wdata, s_rdata;
  logic        s_rvalid, s_err;
  logic [2:0]  s_fill;

  int checks;
  int failures;

`ifdef PW_UB_RAW_BYPASS_EN
  localparam logic [15:0] COLL_EXP = 16'hAAAA;
`else
  localparam logic [15:0] COLL_EXP = 16'h1111;
`endif

  pw_ub_banked_sr u_bank (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .wr_wen(b_wen), .wr_ctrl_vars(b_wcv), .wr_data(b_wdata),
    .rd_ren(b_ren), .rd_ctrl_vars(b_rcv),
    .rd_data(b_rdata), .rd_valid(b_rvalid), .err_oob(b_err), .sr_fill(b_fill)
  );

  pw_ub_banked_sr #(.SR_DEPTH(4)) u_sr (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .wr_wen(s_wen), .wr_ctrl_vars(s_wcv), .wr_data(s_wdata),
    .rd_ren(s_ren), .rd_ctrl_vars(s_rcv),
    .rd_data(s_rdata), .rd_valid(s_rvalid), .err_oob(s_err), .sr_fill(s_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] cv(input int x, input int y);
    return {16'(y), 16'(x), 16'h0000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    b_flush = 0; b_wen = 0; b_ren = 0; b_wcv = '0; b_rcv = '0; b_wdata = '0;
    s_flush = 0; s_wen = 0; s_ren = 0; s_wcv = '0; s_rcv = '0; s_wdata = '0;
    step();
    step();
    chk("rst_b_rvalid", 32'(b_rvalid), 0);
    chk("rst_b_rdata", 32'(b_rdata), 0);
    chk("rst_b_err", 32'(b_err), 0);
    chk("rst_s_fill", 32'(s_fill), 0);
    chk("rst_s_rvalid", 32'(s_rvalid), 0);
    rst_n = 1'b1;

    // Banked fill, raster order, data = x + 64*y.
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 64; x++) begin
        b_wen = 1; b_wcv = cv(x, y); b_wdata = 16'(x + 64 * y);
        step();
      end
    end
    b_wen = 0;
    chk("fill_no_err", 32'(b_err), 0);

    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 64; x++) begin
        b_ren = 1; b_rcv = cv(x, y);
        step();
        chk("readback_data", 32'(b_rdata), 32'(x + 64 * y));
        chk("readback_valid", 32'(b_rvalid), 1);
      end
    end

    b_ren = 0;
    step();
    chk("idle_valid", 32'(b_rvalid), 0);
    chk("idle_hold", 32'(b_rdata), 255);

    // Same-address collision.
    b_wen = 1; b_wcv = cv(5, 3); b_wdata = 16'h1111;
    step();
    b_wdata = 16'hAAAA; b_ren = 1; b_rcv = cv(5, 3);
    step();
    chk("coll_data", 32'(b_rdata), 32'(COLL_EXP));
    b_wen = 0;
    step();
    chk("coll_after", 32'(b_rdata), 32'hAAAA);

    // Different banks in the same cycle.
    b_wen = 1; b_wcv = cv(6, 3); b_wdata = 16'h2222; b_rcv = cv(7, 3);
    step();
    chk("diff_bank_rd", 32'(b_rdata), 199);
    b_wen = 0; b_rcv = cv(6, 3);
    step();
    chk("diff_bank_wr", 32'(b_rdata), 32'h2222);

    // OOB write at x == EXTENT_X.
    b_ren = 0; b_wen = 1; b_wcv = cv(64, 0); b_wdata = 16'hBEEF;
    step();
    chk("oob_wr_err", 32'(b_err), 1);
    b_wen = 0;
    step();
    chk("oob_err_pulse", 32'(b_err), 0);
    b_ren = 1; b_rcv = cv(0, 1);
    step();
    chk("oob_keep_0_1", 32'(b_rdata), 64);
    b_rcv = cv(0, 2);
    step();
    chk("oob_keep_0_2", 32'(b_rdata), 128);

    // OOB read (x) and OOB write (y past bank depth).
    b_rcv = cv(70, 0);
    step();
    chk("oob_rd_err", 32'(b_err), 1);
    chk("oob_rd_valid", 32'(b_rvalid), 0);
    chk("oob_rd_hold", 32'(b_rdata), 128);
    b_ren = 0; b_wen = 1; b_wcv = cv(0, 64);
    step();
    chk("oob_y_err", 32'(b_err), 1);
    b_wen = 0;

    // Banked flush drops the read.
    b_ren = 1; b_rcv = cv(1, 0);
    step();
    chk("pre_flush_valid", 32'(b_rvalid), 1);
    b_flush = 1; b_rcv = cv(2, 0);
    step();
    chk("flush_valid", 32'(b_rvalid), 0);
    chk("flush_hold", 32'(b_rdata), 1);
    b_flush = 0; b_ren = 0;

    // Delay line, depth 4.
    s_wen = 1; s_ren = 1;
    for (int k = 1; k <= 7; k++) begin
      s_wdata = 16'(k);
      step();
      chk("sr_fill", 32'(s_fill), (k < 4) ? k : 4);
      chk("sr_valid", 32'(s_rvalid), (k >= 5) ? 1 : 0);
      if (k >= 5) chk("sr_data", 32'(s_rdata), 32'(k - 4));
    end
    s_wen = 0;
    step();
    chk("sr_pop_only", 32'(s_rdata), 4);
    chk("sr_pop_only_fill", 32'(s_fill), 4);
    s_ren = 0;
    step();
    chk("sr_no_pop", 32'(s_rvalid), 0);

    // Delay-line flush after three pushes.
    s_flush = 1;
    step();
    s_flush = 0; s_wen = 1; s_ren = 1;
    for (int k = 0; k < 3; k++) begin
      s_wdata = 16'(20 + k);
      step();
      chk("sr_refill_valid", 32'(s_rvalid), 0);
      chk("sr_refill_fill", 32'(s_fill), 32'(k + 1));
    end
    s_flush = 1; s_wdata = 16'd23;
    step();
    chk("sr_flush_fill", 32'(s_fill), 0);
    chk("sr_flush_valid", 32'(s_rvalid), 0);
    s_flush = 0;
    for (int k = 0; k < 4; k++) begin
      s_wdata = 16'(30 + k);
      step();
      chk("sr_post_flush_valid", 32'(s_rvalid), 0);
      chk("sr_post_flush_fill", 32'(s_fill), 32'(k + 1));
    end
    s_wdata = 16'd34;
    step();
    chk("sr_post_flush_first", 32'(s_rvalid), 1);
    chk("sr_post_flush_data", 32'(s_rdata), 30);
    s_wen = 0; s_ren = 0;

    // Async reset mid-read.
    b_ren = 1; b_rcv = cv(3, 0);
    step();
    chk("pre_rst_valid", 32'(b_rvalid), 1);
    chk("pre_rst_data", 32'(b_rdata), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(b_rvalid), 0);
    chk("async_rst_data", 32'(b_rdata), 0);
    chk("async_rst_sr_fill", 32'(s_fill), 0);
    chk("async_rst_sr_valid", 32'(s_rvalid), 0);
    step();
    rst_n = 1'b1;
    s_wen = 1; s_ren = 1; s_wdata = 16'd40;
    step();
    chk("post_rst_sr_valid", 32'(s_rvalid), 0);
    chk("post_rst_sr_fill", 32'(s_fill), 1);
    chk("post_rst_b_valid", 32'(b_rvalid), 1);
    s_wen = 0; s_ren = 0; b_ren = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pw_ub_banked_sr.md
Name: pw_ub_banked_sr

Overview:
- Parametrised unified buffer for pointwise-style pipelines; successor to the fixed 2x2-banked, 64-wide, zero-delay buffers.
- Provides cyclic-banked 2-D storage with a real registered read path, plus a configurable-depth circular delay line for stencils whose reader lags the writer by a fixed number of pushes.
- Sits between a producer op (write port) and a consumer op (read port) inside one compute kernel.

Parameters:
- DATA_W, 16, data word width
- CTRL_W, 16, width of each loop control variable
- BANKS_X, 2, banks along dim x (ctrl_vars[1]); power of two, >=1
- BANKS_Y, 2, banks along dim y (ctrl_vars[2]); power of two, >=1
- EXTENT_X, 64, logical row extent; multiple of BANKS_X
- BANK_DEPTH, 1024, words per bank
- SR_DEPTH, 0, delay-line depth in pushes; 0 = banked mode, >0 = delay mode (1..256)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline restart (clears pointers/valids, not storage)
- wr_wen  in  1  write enable
- wr_ctrl_vars  in  3 x CTRL_W  write loop vars; [0] outer (unused), [1]=x, [2]=y
- wr_data  in  DATA_W  write data
- rd_ren  in  1  read enable
- rd_ctrl_vars  in  3 x CTRL_W  read loop vars, same layout
- rd_data  out  DATA_W  read data, registered
- rd_valid  out  1  rd_data holds a valid word this cycle
- err_oob  out  1  one-cycle pulse: out-of-range write/read dropped
- sr_fill  out  $clog2(SR_DEPTH+1) (min 1)  delay-line occupancy

Behaviour:
- Reset (rst_n low, async): rd_data=0, rd_valid=0, err_oob=0, sr_fill=0, SR pointers=0. Storage contents undefined.
- Bank select: bank = (x mod BANKS_X) + BANKS_X*(y mod BANKS_Y). In-bank address = (x/BANKS_X) + (EXTENT_X/BANKS_X)*(y/BANKS_Y). Shifts/masks only, no dividers.
- OOB: in-bank address >= BANK_DEPTH or x >= EXTENT_X -> access dropped, err_oob=1 next cycle.
- Banked mode (SR_DEPTH=0):
  - Write commits on the clk edge with wr_wen=1.
  - Read latency is 1 cycle: rd_ren in cycle N -> rd_data/rd_valid in cycle N+1.
  - rd_valid=0 after any cycle without rd_ren; rd_data holds its last value.
  - Same-cycle read and write to the same bank/address returns the OLD word unless the bypass feature is compiled in.
  - Different banks never conflict.
- Delay mode (SR_DEPTH>0):
  - ctrl_vars are ignored for addressing; OOB is never flagged.
  - Circular buffer of SR_DEPTH entries. wr_wen writes at wptr; wptr wraps SR_DEPTH-1 -> 0.
  - sr_fill increments on wr_wen and saturates at SR_DEPTH.
  - rd_ren with sr_fill==SR_DEPTH -> next cycle rd_data = word written SR_DEPTH pushes before the current push, and rd_valid=1.
  - rd_ren with sr_fill<SR_DEPTH -> rd_valid=0 (underflow, no error).
  - Simultaneous wr_wen and rd_ren reads the oldest entry before it is overwritten.
- flush: next cycle rd_valid=0, err_oob=0, sr_fill=0, wptr=0. Storage is not cleared. Flush takes priority over same-cycle wr_wen/rd_ren, which are dropped.
- Reset asserted mid-operation: all state returns to reset values immediately; the first access after deassertion behaves as after power-up.

Optional Feature:
- Macro PW_UB_RAW_BYPASS_EN.
- Defined: in banked mode, a same-cycle write and read to an identical bank/address forwards wr_data to rd_data next cycle.
- Defined: in delay mode with SR_DEPTH==1, a simultaneous push forwards the new word.
- Undefined: read-before-write semantics as above; no forwarding mux is built.

Decomposition:
- Shared package pw_ub_pkg: ctrl_vec_t (3 x CTRL_W), function bank_of(x,y), function bank_addr(x,y), localparam NBANKS=BANKS_X*BANKS_Y.
- Sub-module pw_ub_delay_line: circular buffer with wptr, fill and read port. Instantiated only under generate when SR_DEPTH>0.

Test Plan:
- Banked fill/readback: write x=0..63, y=0..3 with data=x+64*y; read back in raster order -> each rd_data equals the index, 1-cycle latency, 4 banks hit in 2x2 pattern.
- Same-address collision: write (5,3)=0xAAAA over old 0x1111 while reading (5,3) -> 0x1111 without macro, 0xAAAA with PW_UB_RAW_BYPASS_EN.
- OOB: write x=64 (EXTENT_X=64) -> err_oob pulses one cycle, no bank modified (readback of (0,1) unchanged).
- Delay mode, SR_DEPTH=4: push 1,2,3,4,5,6 with rd_ren every cycle -> rd_valid low for the first 4 pushes; then rd_data = 1,2 ...; sr_fill saturates at 4; wptr wraps.
- Flush mid-stream in delay mode after 3 pushes -> sr_fill=0, rd_valid=0; 4 further pushes are required before rd_valid rises again.
- Async reset asserted mid-read -> rd_valid/rd_data drop to 0 without waiting for a clock edge.
